// File: rtl/mips_pkg.sv
// Shared types and constants for the multi-cycle MIPS instruction fetch path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  // Word placed on if_instr while no instruction has been fetched yet.
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_ERR   = 2'd3
  } fetch_state_t;

  // Sequential PC; wraps modulo 2^32 with no carry-out.
  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

  // Instruction addresses must be word aligned.
  function automatic logic addr_misaligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating count of request cycles that pass without a memory acknowledge.
// Latency: count updates one cycle after enable; timeout is combinational on the count.
// Backpressure: none; clear has priority over enable.
module fetch_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  localparam logic [7:0] LP_MAX = 8'(MAX_WAIT);

  logic [7:0] r_count;

  // Count unacknowledged request cycles, holding at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (clear) begin
      r_count <= 8'd0;
    end else if (enable && (r_count != LP_MAX)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign timeout = (r_count == LP_MAX);

endmodule

// File: rtl/fetch_controller.sv
// PC sequencing and single-outstanding instruction fetch with branch/jump redirect.
// Latency: imem_ack edge -> if_valid the following cycle; at best one instruction per 2 cycles.
// Backpressure: stall holds if_* bit-stable in VALID; no new request is issued until the transfer.
module fetch_controller
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [ADDR_W-1:0]  if_pc_plus4,
  output logic               fetch_err
);

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic               r_pend_vld;
  logic [ADDR_W-1:0]  r_pend_addr;
  logic               r_imem_req;
  logic [ADDR_W-1:0]  r_imem_addr;
  logic               r_if_valid;
  logic [INSTR_W-1:0] r_if_instr;
  logic [ADDR_W-1:0]  r_if_pc;
  logic [ADDR_W-1:0]  r_if_pc_plus4;
  logic               r_fetch_err;

  logic w_req_live;
  logic w_timeout;
  logic w_redir_bad;
  logic w_timed_out;
  logic w_goto_err;

  // A request is live only in REQ with imem_req high; the REQ cycle after a
  // discarded fetch keeps imem_req low and any ack seen then is ignored.
  assign w_req_live  = (r_state == ST_REQ) && r_imem_req;
  assign w_redir_bad = redirect_valid && addr_misaligned(redirect_addr);
  assign w_timed_out = w_req_live && !imem_ack && w_timeout;
  assign w_goto_err  = (r_state != ST_ERR) && (w_redir_bad || w_timed_out);

  fetch_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!w_req_live || imem_ack),
    .enable  (w_req_live && !imem_ack),
    .timeout (w_timeout)
  );

  // Fetch FSM: owns PC, pending redirect and every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_pc          <= RESET_PC;
      r_pend_vld    <= 1'b0;
      r_pend_addr   <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_PC;
      r_if_valid    <= 1'b0;
      r_if_instr    <= NOP_WORD;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_fetch_err   <= 1'b0;
    end else if (w_goto_err) begin
      // Misaligned target or memory timeout: park until reset, no request to the bad address.
      r_state     <= ST_ERR;
      r_fetch_err <= 1'b1;
      r_imem_req  <= 1'b0;
      r_if_valid  <= 1'b0;
      r_pend_vld  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_REQ;
          r_imem_req <= 1'b1;
          if (redirect_valid) begin
            r_pc        <= redirect_addr;
            r_imem_addr <= redirect_addr;
          end else begin
            r_imem_addr <= r_pc;
          end
        end

        ST_REQ: begin
          if (!r_imem_req) begin
            // Bubble after a discarded fetch: issue to the (possibly updated) PC.
            r_imem_req <= 1'b1;
            if (redirect_valid) begin
              r_pc        <= redirect_addr;
              r_imem_addr <= redirect_addr;
            end else begin
              r_imem_addr <= r_pc;
            end
          end else if (imem_ack) begin
            r_pend_vld <= 1'b0;
            r_imem_req <= 1'b0;
            if (redirect_valid || r_pend_vld) begin
              // Fetched word belongs to the wrong path; newest target wins.
              r_pc <= redirect_valid ? redirect_addr : r_pend_addr;
            end else begin
              r_state       <= ST_VALID;
              r_if_valid    <= 1'b1;
              r_if_instr    <= imem_rdata;
              r_if_pc       <= r_pc;
              r_if_pc_plus4 <= pc_inc(r_pc);
              r_pc          <= pc_inc(r_pc);
            end
          end else if (redirect_valid) begin
            // Request in flight: address must stay put, so remember the target.
            r_pend_vld  <= 1'b1;
            r_pend_addr <= redirect_addr;
          end
        end

        ST_VALID: begin
          if (redirect_valid) begin
            // Redirect squashes the presented instruction even if decode would take it.
            r_state     <= ST_REQ;
            r_if_valid  <= 1'b0;
            r_pc        <= redirect_addr;
            r_imem_req  <= 1'b1;
            r_imem_addr <= redirect_addr;
          end else if (!stall) begin
            r_state     <= ST_REQ;
            r_if_valid  <= 1'b0;
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_pc;
          end
        end

        default: begin
          r_state <= ST_ERR;
        end
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;
  assign fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed, table-driven bench for fetch_controller plus hand sequences for errors and reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge after each rising edge.
// A second instance exercises the PC wrap from the top of the address space.
module tb_fetch_controller;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fetch_err;

  logic        w_rst;
  logic        w_stall;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_addr;
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_imem_ack;
  logic [31:0] w_imem_rdata;
  logic        w_if_valid;
  logic [31:0] w_if_instr;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_pc_plus4;
  logic        w_fetch_err;

  int errors = 0;
  int checks = 0;

  fetch_controller dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .fetch_err      (fetch_err)
  );

  fetch_controller #(
    .RESET_PC (32'hFFFF_FFFC),
    .MAX_WAIT (15)
  ) dut_wrap (
    .clk            (clk),
    .rst            (w_rst),
    .stall          (w_stall),
    .redirect_valid (w_redirect_valid),
    .redirect_addr  (w_redirect_addr),
    .imem_req       (w_imem_req),
    .imem_addr      (w_imem_addr),
    .imem_ack       (w_imem_ack),
    .imem_rdata     (w_imem_rdata),
    .if_valid       (w_if_valid),
    .if_instr       (w_if_instr),
    .if_pc          (w_if_pc),
    .if_pc_plus4    (w_if_pc_plus4),
    .fetch_err      (w_fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        rv;
    logic [31:0] ra;
    logic        ack;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic [31:0] e_p4;
    logic        e_err;
  } vec_t;

  vec_t vt[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_v(input int i, input logic st, input logic rv, input logic [31:0] ra,
                       input logic ack, input logic [31:0] rd, input logic e_req,
                       input logic [31:0] e_addr, input logic e_vld, input logic [31:0] e_instr,
                       input logic [31:0] e_pc, input logic [31:0] e_p4);
    vt[i].st = st;   vt[i].rv = rv;   vt[i].ra = ra;   vt[i].ack = ack;   vt[i].rd = rd;
    vt[i].e_req = e_req;   vt[i].e_addr = e_addr;   vt[i].e_vld = e_vld;
    vt[i].e_instr = e_instr;   vt[i].e_pc = e_pc;   vt[i].e_p4 = e_p4;   vt[i].e_err = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;  stall = 1'b0;  redirect_valid = 1'b0;  redirect_addr = '0;
    imem_ack = 1'b0;  imem_rdata = '0;
    w_rst = 1'b1;  w_stall = 1'b0;  w_redirect_valid = 1'b0;  w_redirect_addr = '0;
    w_imem_ack = 1'b0;  w_imem_rdata = '0;

    //      i  st rv ra            ack rd            req addr          vld instr         pc            pc+4
    set_v(0,  0, 0, 32'h0,        0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0,        32'h0);
    set_v(1,  0, 0, 32'h0,        0, 32'h0,         1, 32'h0,         0, 32'h0,         32'h0,        32'h0);
    set_v(2,  0, 0, 32'h0,        1, 32'h2008_0005, 0, 32'h0,         1, 32'h2008_0005, 32'h0,        32'h4);
    set_v(3,  1, 0, 32'h0,        0, 32'h0,         0, 32'h0,         1, 32'h2008_0005, 32'h0,        32'h4);
    set_v(4,  1, 0, 32'h0,        0, 32'h0,         0, 32'h0,         1, 32'h2008_0005, 32'h0,        32'h4);
    set_v(5,  1, 0, 32'h0,        0, 32'h0,         0, 32'h0,         1, 32'h2008_0005, 32'h0,        32'h4);
    set_v(6,  0, 0, 32'h0,        0, 32'h0,         1, 32'h4,         0, 32'h2008_0005, 32'h0,        32'h4);
    set_v(7,  0, 1, 32'h40,       0, 32'h0,         1, 32'h4,         0, 32'h2008_0005, 32'h0,        32'h4);
    set_v(8,  0, 0, 32'h0,        0, 32'h0,         1, 32'h4,         0, 32'h2008_0005, 32'h0,        32'h4);
    set_v(9,  0, 0, 32'h0,        1, 32'hDEAD_BEEF, 0, 32'h4,         0, 32'h2008_0005, 32'h0,        32'h4);
    set_v(10, 0, 0, 32'h0,        0, 32'h0,         1, 32'h40,        0, 32'h2008_0005, 32'h0,        32'h4);
    set_v(11, 0, 0, 32'h0,        1, 32'h8C01_0000, 0, 32'h40,        1, 32'h8C01_0000, 32'h40,       32'h44);
    set_v(12, 1, 1, 32'h80,       0, 32'h0,         1, 32'h80,        0, 32'h8C01_0000, 32'h40,       32'h44);
    set_v(13, 0, 0, 32'h0,        1, 32'h0000_0020, 0, 32'h80,        1, 32'h0000_0020, 32'h80,       32'h84);
    set_v(14, 0, 0, 32'h0,        0, 32'h0,         1, 32'h84,        0, 32'h0000_0020, 32'h80,       32'h84);
    set_v(15, 0, 1, 32'h100,      1, 32'h0000_1111, 0, 32'h84,        0, 32'h0000_0020, 32'h80,       32'h84);
    set_v(16, 0, 0, 32'h0,        0, 32'h0,         1, 32'h100,       0, 32'h0000_0020, 32'h80,       32'h84);
    set_v(17, 0, 0, 32'h0,        1, 32'h0000_2222, 0, 32'h100,       1, 32'h0000_2222, 32'h100,      32'h104);
    set_v(18, 0, 1, 32'h200,      0, 32'h0,         1, 32'h200,       0, 32'h0000_2222, 32'h100,      32'h104);
    set_v(19, 0, 1, 32'h300,      0, 32'h0,         1, 32'h200,       0, 32'h0000_2222, 32'h100,      32'h104);
    set_v(20, 0, 1, 32'h400,      0, 32'h0,         1, 32'h200,       0, 32'h0000_2222, 32'h100,      32'h104);
    set_v(21, 0, 0, 32'h0,        1, 32'h0000_3333, 0, 32'h200,       0, 32'h0000_2222, 32'h100,      32'h104);
    set_v(22, 0, 0, 32'h0,        0, 32'h0,         1, 32'h400,       0, 32'h0000_2222, 32'h100,      32'h104);
    set_v(23, 0, 0, 32'h0,        1, 32'h0000_3333, 0, 32'h400,       1, 32'h0000_3333, 32'h400,      32'h404);

    // Reset state
    @(negedge clk);
    chk("rst imem_req",  {31'b0, imem_req},  32'h0);
    chk("rst imem_addr", imem_addr,          32'h0);
    chk("rst if_valid",  {31'b0, if_valid},  32'h0);
    chk("rst if_instr",  if_instr,           32'h0);
    chk("rst if_pc",     if_pc,              32'h0);
    chk("rst if_pc_p4",  if_pc_plus4,        32'h0);
    chk("rst fetch_err", {31'b0, fetch_err}, 32'h0);
    rst = 1'b0;

    // Main table: fetch, stall, pending/present/latest redirect, squash.
    for (int i = 0; i < 24; i++) begin
      stall = vt[i].st;  redirect_valid = vt[i].rv;  redirect_addr = vt[i].ra;
      imem_ack = vt[i].ack;  imem_rdata = vt[i].rd;
      step();
      chk($sformatf("v%0d imem_req", i),  {31'b0, imem_req},  {31'b0, vt[i].e_req});
      chk($sformatf("v%0d imem_addr", i), imem_addr,          vt[i].e_addr);
      chk($sformatf("v%0d if_valid", i),  {31'b0, if_valid},  {31'b0, vt[i].e_vld});
      chk($sformatf("v%0d if_instr", i),  if_instr,           vt[i].e_instr);
      chk($sformatf("v%0d if_pc", i),     if_pc,              vt[i].e_pc);
      chk($sformatf("v%0d if_pc_p4", i),  if_pc_plus4,        vt[i].e_p4);
      chk($sformatf("v%0d fetch_err", i), {31'b0, fetch_err}, {31'b0, vt[i].e_err});
    end

    // Misaligned redirect from VALID -> ERR, no request to 0x42.
    stall = 1'b0;  redirect_valid = 1'b1;  redirect_addr = 32'h42;  imem_ack = 1'b0;
    step();
    chk("mis fetch_err", {31'b0, fetch_err}, 32'h1);
    chk("mis imem_req",  {31'b0, imem_req},  32'h0);
    chk("mis if_valid",  {31'b0, if_valid},  32'h0);
    // ERR ignores all inputs.
    redirect_addr = 32'h600;  imem_ack = 1'b1;  imem_rdata = 32'h7777_7777;
    step();
    step();
    chk("err hold fetch_err", {31'b0, fetch_err}, 32'h1);
    chk("err hold imem_req",  {31'b0, imem_req},  32'h0);
    chk("err hold if_valid",  {31'b0, if_valid},  32'h0);
    chk("err hold imem_addr", imem_addr,          32'h400);
    redirect_valid = 1'b0;  imem_ack = 1'b0;

    // Reset clears the sticky error asynchronously.
    #2 rst = 1'b1;
    #1;
    chk("rst clr fetch_err", {31'b0, fetch_err}, 32'h0);
    chk("rst clr imem_addr", imem_addr,          32'h0);
    step();
    rst = 1'b0;

    // Timeout: no ack at all.
    step();
    chk("to first req", {31'b0, imem_req}, 32'h1);
    for (int k = 0; k < 15; k++) @(posedge clk);
    @(negedge clk);
    chk("to before limit", {31'b0, fetch_err}, 32'h0);
    step();
    chk("to fetch_err", {31'b0, fetch_err}, 32'h1);
    chk("to imem_req",  {31'b0, imem_req},  32'h0);
    #2 rst = 1'b1;
    #1;
    chk("to rst clr", {31'b0, fetch_err}, 32'h0);
    step();
    rst = 1'b0;

    // Reset mid-request with a pending redirect; late ack ignored in IDLE.
    step();
    redirect_valid = 1'b1;  redirect_addr = 32'h500;
    step();
    redirect_valid = 1'b0;
    chk("midrst pre req", {31'b0, imem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("midrst imem_req", {31'b0, imem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b0;  imem_ack = 1'b1;  imem_rdata = 32'h0000_5555;
    step();
    chk("midrst idle ack vld", {31'b0, if_valid}, 32'h0);
    chk("midrst req addr",     imem_addr,         32'h0);
    step();
    chk("midrst fetch vld",   {31'b0, if_valid}, 32'h1);
    chk("midrst fetch instr", if_instr,          32'h0000_5555);
    chk("midrst fetch pc",    if_pc,             32'h0);
    imem_ack = 1'b0;

    // PC wrap from 0xFFFF_FFFC.
    chk("wrap rst addr", w_imem_addr, 32'hFFFF_FFFC);
    w_rst = 1'b0;
    step();
    chk("wrap req addr", w_imem_addr, 32'hFFFF_FFFC);
    w_imem_ack = 1'b1;  w_imem_rdata = 32'h0A0B_0C0D;
    step();
    w_imem_ack = 1'b0;
    chk("wrap if_pc",    w_if_pc,       32'hFFFF_FFFC);
    chk("wrap if_pc_p4", w_if_pc_plus4, 32'h0);
    chk("wrap if_instr", w_if_instr,    32'h0A0B_0C0D);
    step();
    chk("wrap next req",  {31'b0, w_imem_req}, 32'h1);
    chk("wrap next addr", w_imem_addr,         32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
